// File: rtl/cz_flag_unit_pkg.sv
// Shared opcodes, condition codes and the in-flight flag slot type for the C/Z path.
// Pure declarations: no logic and no latency.
// Backpressure is not applicable here.
package cz_flag_unit_pkg;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_NDU = 4'b0010;

    localparam logic [1:0] COND_NONE = 2'b00;
    localparam logic [1:0] COND_Z    = 2'b01;
    localparam logic [1:0] COND_C    = 2'b10;

    localparam int CZ_C_BIT = 1;
    localparam int CZ_Z_BIT = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] we;
        logic [1:0] cz;
        logic [1:0] prev_cz;
        logic       cond_ok;
    } cz_slot_t;

endpackage

// File: rtl/cz_cond_eval.sv
// Decides whether a conditional ADD/NDU-class instruction executes, given the flags it sees.
// Purely combinational, with zero latency.
// No backpressure.
module cz_cond_eval
    import cz_flag_unit_pkg::*;
(
    input  logic [3:0] aluop,
    input  logic [1:0] irlast,
    input  logic [1:0] cz,
    output logic       cond_ok
);

    always_comb begin
        cond_ok = 1'b1;
        if ((aluop == ALUOP_ADD) || (aluop == ALUOP_NDU)) begin
            cond_ok = (irlast == COND_NONE)
                    | ((irlast == COND_Z) & cz[CZ_Z_BIT])
                    | ((irlast == COND_C) & cz[CZ_C_BIT]);
        end
    end

endmodule

// File: rtl/cz_flag_unit.sv
// Owns the architectural C/Z flags, tracks pending updates in MEM/WB and forwards the youngest to EX.
// EX forwarding has zero latency; commit to cz_arch happens 3 clocks after EX.
// stall holds both slots and blocks commit; flushes are ignored while stalled.
module cz_flag_unit
    import cz_flag_unit_pkg::*;
#(
    parameter logic [1:0] RESET_CZ = 2'b00,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       ex_valid,
    input  logic [3:0] ex_aluop,
    input  logic [1:0] ex_irlast,
    input  logic [1:0] ex_cz_we,
    input  logic [1:0] ex_cz_new,
    input  logic       mem_is_load,
    input  logic       mem_load_zero,
    input  logic       flush_ex,
    input  logic       flush_mem,
    output logic [1:0] ex_prev_cz,
    output logic       ex_cond_ok,
    output logic [1:0] wb_prev_cz,
    output logic       wb_cond_ok,
    output logic [1:0] cz_arch
);

    cz_slot_t   mem_q;
    cz_slot_t   wb_q;
    cz_slot_t   mem_eff;
    cz_slot_t   ex_slot;
    logic [1:0] fwd_cz;

    // A load in MEM writes Z from its data; C passes through untouched.
    always_comb begin
        mem_eff = mem_q;
        if (mem_q.v && mem_is_load) begin
            mem_eff.we[CZ_Z_BIT] = 1'b1;
            mem_eff.cz[CZ_Z_BIT] = mem_load_zero;
        end
    end

    always_comb begin
        fwd_cz = cz_arch;
        for (int b = 0; b < 2; b++) begin
            if (wb_q.v && wb_q.we[b]) begin
                fwd_cz[b] = wb_q.cz[b];
            end
            if (mem_eff.v && mem_eff.we[b]) begin
                fwd_cz[b] = mem_eff.cz[b];
            end
        end
    end

    assign ex_prev_cz = FWD_EN ? fwd_cz : cz_arch;

    cz_cond_eval u_cond_eval (
        .aluop   (ex_aluop),
        .irlast  (ex_irlast),
        .cz      (ex_prev_cz),
        .cond_ok (ex_cond_ok)
    );

    always_comb begin
        ex_slot         = '0;
        ex_slot.v       = ex_valid & ~flush_ex;
        ex_slot.we      = ex_slot.v ? (ex_cz_we & {2{ex_cond_ok & ex_valid}}) : 2'b00;
        ex_slot.cz      = ex_cz_new;
        ex_slot.prev_cz = ex_prev_cz;
        ex_slot.cond_ok = ex_cond_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cz_arch <= RESET_CZ;
            mem_q   <= '0;
            wb_q    <= '0;
        end else if (!stall) begin
            mem_q   <= ex_slot;
            wb_q    <= mem_eff;
            wb_q.v  <= mem_q.v & ~flush_mem;
            if (wb_q.v) begin
                cz_arch <= (cz_arch & ~wb_q.we) | (wb_q.cz & wb_q.we);
            end
        end
    end

    assign wb_prev_cz = wb_q.v ? wb_q.prev_cz : 2'b00;
    assign wb_cond_ok = wb_q.v & wb_q.cond_ok;

endmodule

// File: tb/tb_cz_flag_unit.sv
// Directed scenarios plus randomized traffic for cz_flag_unit, checked against an
// in-flight-update queue model of the flag semantics.
module tb_cz_flag_unit;

    localparam logic [1:0] RST_CZ = 2'b00;

    logic       clk = 1'b0;
    logic       reset, stall, ex_valid, mem_is_load, mem_load_zero, flush_ex, flush_mem;
    logic [3:0] ex_aluop;
    logic [1:0] ex_irlast, ex_cz_we, ex_cz_new;
    logic [1:0] ex_prev_cz, wb_prev_cz, cz_arch;
    logic       ex_cond_ok, wb_cond_ok;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cz_flag_unit #(.RESET_CZ(RST_CZ), .FWD_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_aluop      (ex_aluop),
        .ex_irlast     (ex_irlast),
        .ex_cz_we      (ex_cz_we),
        .ex_cz_new     (ex_cz_new),
        .mem_is_load   (mem_is_load),
        .mem_load_zero (mem_load_zero),
        .flush_ex      (flush_ex),
        .flush_mem     (flush_mem),
        .ex_prev_cz    (ex_prev_cz),
        .ex_cond_ok    (ex_cond_ok),
        .wb_prev_cz    (wb_prev_cz),
        .wb_cond_ok    (wb_cond_ok),
        .cz_arch       (cz_arch)
    );

    // Reference model: committed flags plus a queue of in-flight updates, youngest at index 0.
    typedef struct {
        bit       v;
        bit [1:0] we;
        bit [1:0] cz;
        bit [1:0] prev;
        bit       cond;
    } upd_t;

    bit [1:0] m_arch;
    upd_t     inflight[$];

    function automatic bit exp_cond(bit [3:0] op, bit [1:0] ir, bit [1:0] cz);
        if (op != 4'd0 && op != 4'd2) return 1'b1;
        case (ir)
            2'd0:    return 1'b1;
            2'd1:    return cz[0];
            2'd2:    return cz[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic upd_t mem_view();
        upd_t r = inflight[0];
        if (r.v && mem_is_load) begin
            r.we[0] = 1'b1;
            r.cz[0] = mem_load_zero;
        end
        return r;
    endfunction

    function automatic bit [1:0] exp_fwd();
        upd_t     q[2];
        bit [1:0] res;
        q[0] = mem_view();
        q[1] = inflight[1];
        for (int b = 0; b < 2; b++) begin
            res[b] = m_arch[b];
            for (int k = 1; k >= 0; k--) begin
                if (q[k].v && q[k].we[b]) res[b] = q[k].cz[b];
            end
        end
        return res;
    endfunction

    function automatic void model_reset();
        upd_t z = '{default: 0};
        m_arch   = RST_CZ;
        inflight = {z, z};
    endfunction

    function automatic void model_clock();
        upd_t     n, m, w;
        bit [1:0] seen;
        if (reset) begin
            model_reset();
            return;
        end
        if (stall) return;
        seen   = exp_fwd();
        n.v    = ex_valid && !flush_ex;
        n.cond = exp_cond(ex_aluop, ex_irlast, seen);
        n.we   = (n.v && n.cond) ? ex_cz_we : 2'b00;
        n.cz   = ex_cz_new;
        n.prev = seen;
        m      = mem_view();
        m.v    = m.v && !flush_mem;
        w      = inflight[1];
        if (w.v) begin
            for (int b = 0; b < 2; b++) if (w.we[b]) m_arch[b] = w.cz[b];
        end
        inflight = {n, m};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; ex_valid = 0; ex_aluop = 4'h0; ex_irlast = 2'b00;
        ex_cz_we = 2'b00; ex_cz_new = 2'b00; mem_is_load = 0; mem_load_zero = 0;
        flush_ex = 0; flush_mem = 0;
    endtask

    task automatic set_ex(input logic [3:0] op, input logic [1:0] ir, input logic [1:0] we,
                          input logic [1:0] nw);
        ex_valid = 1; ex_aluop = op; ex_irlast = ir; ex_cz_we = we; ex_cz_new = nw;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cz_arch !== RST_CZ) begin failures++; $display("FAIL reset_cz_arch got=%b want=%b", cz_arch, RST_CZ); end
        checks++; if (ex_prev_cz !== RST_CZ) begin failures++; $display("FAIL reset_ex_prev got=%b want=%b", ex_prev_cz, RST_CZ); end
        checks++; if (wb_prev_cz !== 2'b00) begin failures++; $display("FAIL reset_wb_prev got=%b want=00", wb_prev_cz); end
        checks++; if (wb_cond_ok !== 1'b0) begin failures++; $display("FAIL reset_wb_cond got=%b want=0", wb_cond_ok); end
    endtask

    task automatic test_add_commit();
        do_reset();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b10);
        #1;
        checks++; if (ex_cond_ok !== 1'b1) begin failures++; $display("FAIL add_cond got=%b want=1", ex_cond_ok); end
        tick();
        idle_inputs();
        tick();
        checks++; if (cz_arch !== 2'b00) begin failures++; $display("FAIL add_early_commit got=%b want=00", cz_arch); end
        checks++; if (wb_cond_ok !== 1'b1) begin failures++; $display("FAIL add_wb_cond got=%b want=1", wb_cond_ok); end
        tick();
        checks++; if (cz_arch !== 2'b10) begin failures++; $display("FAIL add_commit got=%b want=10", cz_arch); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b10);
        tick();
        set_ex(4'b0000, 2'b10, 2'b11, 2'b01);
        #1;
        checks++; if (ex_prev_cz[1] !== 1'b1) begin failures++; $display("FAIL b2b_fwd_c got=%b want=1", ex_prev_cz[1]); end
        checks++; if (ex_cond_ok !== 1'b1) begin failures++; $display("FAIL b2b_adc_cond got=%b want=1", ex_cond_ok); end
        tick();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b00);
        tick();
        set_ex(4'b0000, 2'b10, 2'b11, 2'b11);
        #1;
        checks++; if (ex_prev_cz !== 2'b00) begin failures++; $display("FAIL b2b_fwd_clear got=%b want=00", ex_prev_cz); end
        checks++; if (ex_cond_ok !== 1'b0) begin failures++; $display("FAIL b2b_adc_skip got=%b want=0", ex_cond_ok); end
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (cz_arch !== 2'b00) begin failures++; $display("FAIL b2b_suppressed got=%b want=00", cz_arch); end
    endtask

    task automatic test_load_override();
        do_reset();
        set_ex(4'b0110, 2'b00, 2'b00, 2'b00);
        tick();
        set_ex(4'b0000, 2'b01, 2'b11, 2'b10);
        mem_is_load = 1; mem_load_zero = 1;
        #1;
        checks++; if (ex_prev_cz[0] !== 1'b1) begin failures++; $display("FAIL load_fwd_z got=%b want=1", ex_prev_cz[0]); end
        checks++; if (ex_cond_ok !== 1'b1) begin failures++; $display("FAIL load_adz_cond got=%b want=1", ex_cond_ok); end
        tick();
        idle_inputs();
        tick();
        checks++; if (cz_arch !== 2'b01) begin failures++; $display("FAIL load_commit_z got=%b want=01", cz_arch); end
        tick();
        checks++; if (cz_arch !== 2'b10) begin failures++; $display("FAIL load_adz_commit got=%b want=10", cz_arch); end
    endtask

    task automatic test_flush();
        do_reset();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b11);
        flush_ex = 1;
        tick();
        idle_inputs();
        set_ex(4'b0000, 2'b00, 2'b00, 2'b00);
        #1;
        checks++; if (ex_prev_cz !== 2'b00) begin failures++; $display("FAIL flush_fwd got=%b want=00", ex_prev_cz); end
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (cz_arch !== 2'b00) begin failures++; $display("FAIL flush_arch got=%b want=00", cz_arch); end
    endtask

    task automatic test_stall();
        logic [1:0] snap_ex, snap_wb;
        logic       snap_wbc;
        do_reset();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b10);
        tick();
        set_ex(4'b0001, 2'b00, 2'b01, 2'b01);
        tick();
        idle_inputs();
        stall = 1;
        #1;
        snap_ex = ex_prev_cz; snap_wb = wb_prev_cz; snap_wbc = wb_cond_ok;
        for (int i = 0; i < 4; i++) begin
            flush_ex = 1; flush_mem = 1;
            tick();
            checks++; if (cz_arch !== 2'b00) begin failures++; $display("FAIL stall_no_commit cyc=%0d got=%b want=00", i, cz_arch); end
            checks++; if ({ex_prev_cz, wb_prev_cz, wb_cond_ok} !== {snap_ex, snap_wb, snap_wbc}) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%b want=%b", i, {ex_prev_cz, wb_prev_cz, wb_cond_ok}, {snap_ex, snap_wb, snap_wbc});
            end
        end
        idle_inputs();
        tick();
        checks++; if (cz_arch !== 2'b10) begin failures++; $display("FAIL stall_release got=%b want=10", cz_arch); end
        tick();
        checks++; if (cz_arch !== 2'b11) begin failures++; $display("FAIL stall_second got=%b want=11", cz_arch); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b11);
        tick();
        set_ex(4'b0000, 2'b00, 2'b11, 2'b10);
        tick();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++; if (cz_arch !== RST_CZ) begin failures++; $display("FAIL rstp_arch got=%b want=%b", cz_arch, RST_CZ); end
        checks++; if (wb_cond_ok !== 1'b0) begin failures++; $display("FAIL rstp_wb_cond got=%b want=0", wb_cond_ok); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (cz_arch !== RST_CZ) begin failures++; $display("FAIL rstp_late_commit got=%b want=%b", cz_arch, RST_CZ); end
    endtask

    task automatic test_random();
        logic [1:0] e_fwd;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_aluop      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                          : (($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0010);
            ex_irlast     = 2'($urandom_range(0, 3));
            ex_cz_we      = 2'($urandom_range(0, 3));
            ex_cz_new     = 2'($urandom_range(0, 3));
            mem_is_load   = ($urandom_range(0, 3) == 0);
            mem_load_zero = 1'($urandom_range(0, 1));
            flush_ex      = ($urandom_range(0, 7) == 0);
            flush_mem     = ($urandom_range(0, 7) == 0);
            #1;
            e_fwd = exp_fwd();
            checks++; if (ex_prev_cz !== e_fwd) begin failures++; $display("FAIL rnd_ex_prev cyc=%0d got=%b want=%b", i, ex_prev_cz, e_fwd); end
            checks++; if (ex_cond_ok !== exp_cond(ex_aluop, ex_irlast, e_fwd)) begin
                failures++; $display("FAIL rnd_ex_cond cyc=%0d got=%b want=%b", i, ex_cond_ok, exp_cond(ex_aluop, ex_irlast, e_fwd));
            end
            checks++; if (wb_prev_cz !== (inflight[1].v ? inflight[1].prev : 2'b00)) begin
                failures++; $display("FAIL rnd_wb_prev cyc=%0d got=%b want=%b", i, wb_prev_cz, inflight[1].v ? inflight[1].prev : 2'b00);
            end
            checks++; if (wb_cond_ok !== (inflight[1].v && inflight[1].cond)) begin
                failures++; $display("FAIL rnd_wb_cond cyc=%0d got=%b want=%b", i, wb_cond_ok, inflight[1].v && inflight[1].cond);
            end
            checks++; if (cz_arch !== m_arch) begin failures++; $display("FAIL rnd_cz_arch cyc=%0d got=%b want=%b", i, cz_arch, m_arch); end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_add_commit();
        test_back_to_back();
        test_load_override();
        test_flush();
        test_stall();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cz_flag_unit.md
Name: cz_flag_unit

Overview:
- Producer side of the carry/zero condition-code path. Owns the architectural C/Z flag register.
- Tracks in-flight flag updates through EX->MEM->WB and forwards the youngest pending C/Z value to the instruction in EX.
- Supplies the prev_cz value and condition-met bit that the writeback register-write gating consumes.
- Sits beside the EX/MEM/WB pipeline registers of the IITB-RISC pipeline and commits flags only at WB.

Parameters:
- RESET_CZ, 2'b00: architectural {C,Z} value after reset.
- FWD_EN, 1: 1 forwards pending updates to EX; 0 always presents architectural flags (debug only).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  global pipeline stall; all stage slots hold.
- ex_valid  in  1  EX slot holds a live instruction.
- ex_aluop  in  4  ALU opcode of the EX instruction.
- ex_irlast  in  2  IR[1:0] of the EX instruction: 00 unconditional, 01 execute-if-Z, 10 execute-if-C.
- ex_cz_we  in  2  flags the instruction writes, [1]=C, [0]=Z.
- ex_cz_new  in  2  ALU-produced {C,Z}.
- mem_is_load  in  1  MEM instruction is a load; it writes Z from load data.
- mem_load_zero  in  1  load data equals zero.
- flush_ex  in  1  kill the EX instruction; no capture into MEM.
- flush_mem  in  1  kill the MEM instruction; no capture into WB.
- ex_prev_cz  out  2  {C,Z} seen by the EX instruction (forwarded).
- ex_cond_ok  out  1  condition met for the EX instruction.
- wb_prev_cz  out  2  {C,Z} seen by the WB instruction when it was in EX (feeds prev_cz_wb).
- wb_cond_ok  out  1  condition-met bit for the WB instruction.
- cz_arch  out  2  committed {C,Z}.

Behaviour:
- Flag encoding everywhere: bit1 = C, bit0 = Z.
- Condition rule: for ex_aluop 4'b0000 or 4'b0010:
  - cond_ok = (irlast==00) | (irlast==01 & Z) | (irlast==10 & C), using ex_prev_cz.
  - Any other aluop: cond_ok = 1.
- Effective write enable: eff_we = ex_cz_we & {2{cond_ok & ex_valid}}.
- Slots are registered: MEM slot {v, we, cz, prev_cz, cond_ok} and WB slot {same}.
  - Each advances on every clock with stall=0.
  - Each holds with stall=1.
- EX->MEM capture:
  - v = ex_valid & ~flush_ex.
  - we = eff_we when v, else 00.
- MEM stage load override:
  - If mem v & mem_is_load: Z write enable forced to 1 and Z value = mem_load_zero; this override is captured into WB.
  - C is unaffected by the load.
- MEM->WB capture: v = mem v & ~flush_mem.
- WB commit: on a non-stalled clock with WB v, for each bit with we set, cz_arch bit <= WB cz bit. All other bits hold. Bits with we clear never change.
- Forwarding (combinational), applied per bit, youngest first:
  - MEM slot (v & we bit), including the load Z override;
  - else WB slot (v & we bit);
  - else cz_arch.
  - Result drives ex_prev_cz.
- Latency:
  - A flag written by instruction i is visible to i+1 in EX with 0 stall cycles.
  - It appears in cz_arch 3 clocks after i leaves EX.
- Simultaneous events:
  - flush_ex and flush_mem in the same cycle kill both captures.
  - A WB commit still occurs that cycle.
  - stall=1 with flush asserted: flushes are ignored while stalled; the pipeline re-asserts them after the stall.
- Reset, synchronous, overrides stall and flush:
  - cz_arch = RESET_CZ.
  - Both slots: v=0, we=00, cz=00, prev_cz=00, cond_ok=0.
  - Outputs after reset: wb_prev_cz=00, wb_cond_ok=0, ex_prev_cz=RESET_CZ.
  - Reset mid-operation discards all pending updates.
- wb_prev_cz and wb_cond_ok are the WB slot fields, read 00/0 when WB v=0.

Decomposition:
- Shared package holds:
  - ALUOP_ADD=4'b0000, ALUOP_NDU=4'b0010, COND_NONE=2'b00, COND_Z=2'b01, COND_C=2'b10;
  - CZ_C_BIT=1, CZ_Z_BIT=0;
  - a flag-slot struct typedef {v, we[1:0], cz[1:0], prev_cz[1:0], cond_ok}.
- One sub-module, cz_cond_eval: combinational cond_ok from aluop, irlast and cz. It is reused by EX gating and by tests.

Test Plan:
- Reset with RESET_CZ=2'b00, then ADD (aluop 0000, irlast 00, we 11, new 10) -> ex_cond_ok=1; cz_arch=10 after 3 clocks.
- Back-to-back: ADD sets C=1, next-cycle ADC (irlast 10) -> ex_prev_cz[1]=1 from the MEM forward, ex_cond_ok=1; ADC with C=0 -> ex_cond_ok=0, its we suppressed, cz_arch unchanged.
- Load in MEM with mem_load_zero=1 while an ADZ (irlast 01) is in EX -> ex_prev_cz[0]=1, cond_ok=1; cz_arch Z=1 after commit.
- flush_ex on a flag-writing ADD with new 11 -> cz_arch stays 00; the next instruction sees ex_prev_cz=00.
- stall held 4 cycles with MEM/WB slots full -> no commit, outputs constant; the commit happens on the first unstalled clock.
- Reset asserted while two updates are pending -> next cycle cz_arch=RESET_CZ, wb_cond_ok=0, no later commit.
